// File: rtl/bus_pkg.sv
// bus_pkg: shared state encodings and mux-select values for the bus arbiter
package bus_pkg;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] G1   = 2'd1;
    localparam logic [1:0] G2   = 2'd2;
    localparam logic MSEL_M1 = 1'b0;
    localparam logic MSEL_M2 = 1'b1;
endpackage

// File: rtl/arb_timer.sv
// arb_timer: inactivity counter for the granted master
//  clk, rst   clock, async active-high reset
//  clr        clear counter (mvalid seen or grant ending)
//  inc        count one idle cycle of the granted master
//  expired    counter has reached TOUT_CYC-1
module arb_timer #(
    parameter int TOUT_W   = 4,
    parameter int TOUT_CYC = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expired
);
    localparam logic [TOUT_W-1:0] LAST = TOUT_W'(TOUT_CYC - 1);
    logic [TOUT_W-1:0] cnt;
    assign expired = cnt == LAST;
    // saturates so a timeout blocked by busy slaves fires as soon as they go idle
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master bus arbiter with round-robin/fixed priority and inactivity timeout
//  clk, rst          clock, async active-high reset
//  breq1, breq2      level bus requests
//  mvalid            muxed mvalid of the selected master
//  sready            1 = no slave transaction in flight
//  bgrant1, bgrant2  registered grants
//  msel              registered mux select (0 = master 1, 1 = master 2)
//  tout              one-cycle pulse on timeout revocation
import bus_pkg::*;
module bus_arbiter #(
    parameter bit RR_EN    = 1'b1,
    parameter int TOUT_W   = 4,
    parameter int TOUT_CYC = 12
) (
    input  logic clk,
    input  logic rst,
    input  logic breq1,
    input  logic breq2,
    input  logic mvalid,
    input  logic sready,
    output logic bgrant1,
    output logic bgrant2,
    output logic msel,
    output logic tout
);
    logic [1:0] state, nxt, arb;
    logic last, busy, own_req, rel, tmo, expired;
    always_comb begin
        busy    = state == G1 || state == G2;
        own_req = state == G1 ? breq1 : breq2;
        rel     = busy && !own_req && sready;
        // a coinciding release wins, so tout only flags genuine revocations
        tmo     = busy && expired && !mvalid && sready && !rel;
        arb     = breq1 && breq2 ? ((RR_EN && last == MSEL_M1) ? G2 : G1) :
                  breq1 ? G1 : breq2 ? G2 : IDLE;
        // grants always return through IDLE, so owners never switch directly
        nxt     = busy ? ((rel || tmo) ? IDLE : state) : arb;
    end
    arb_timer #(.TOUT_W(TOUT_W), .TOUT_CYC(TOUT_CYC)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(mvalid || nxt == IDLE),
        .inc(busy),
        .expired(expired)
    );
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state   <= IDLE;
            bgrant1 <= 1'b0;
            bgrant2 <= 1'b0;
            msel    <= MSEL_M1;
            tout    <= 1'b0;
            last    <= MSEL_M2;
        end else begin
            state   <= nxt;
            bgrant1 <= nxt == G1;
            bgrant2 <= nxt == G2;
            msel    <= nxt == G1 ? MSEL_M1 : nxt == G2 ? MSEL_M2 : msel;
            tout    <= tmo;
            // msel names the current owner while a grant is held
            last    <= (rel || tmo) ? msel : last;
        end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: scoreboard bench, expected output changes queued with their cycle
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst, breq1, breq2, mvalid, sready;
    logic bgrant1, bgrant2, msel, tout;
    int cyc = 0;
    int nvec = 0;
    int errs = 0;
    typedef struct {
        int cyc;
        logic [3:0] v;
    } exp_t;
    exp_t q[$];
    logic [3:0] prev = 4'b0000;

    bus_arbiter #(.RR_EN(1'b1), .TOUT_W(4), .TOUT_CYC(12)) dut (
        .clk(clk),
        .rst(rst),
        .breq1(breq1),
        .breq2(breq2),
        .mvalid(mvalid),
        .sready(sready),
        .bgrant1(bgrant1),
        .bgrant2(bgrant2),
        .msel(msel),
        .tout(tout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push(int d, logic [3:0] v);
        q.push_back('{cyc + d, v});
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(string name, logic [3:0] act, logic [3:0] exp_v);
        nvec++;
        if (act !== exp_v) begin
            errs++;
            $display("FAIL %s: got g1g2ms_to=%b want %b", name, act, exp_v);
        end
    endtask

    // monitor: any change of {bgrant1,bgrant2,msel,tout} must match the next queued event
    always @(negedge clk) begin
        logic [3:0] obs;
        exp_t e;
        obs = {bgrant1, bgrant2, msel, tout};
        nvec++;
        if ((bgrant1 && bgrant2) || (((prev[3] && bgrant1) || (prev[2] && bgrant2)) && msel !== prev[1])) begin
            errs++;
            $display("FAIL grant_excl cyc %0d: got %b prev %b", cyc, obs, prev);
        end
        if (obs !== prev || (q.size() > 0 && q[0].cyc == cyc)) begin
            nvec++;
            if (q.size() == 0) begin
                errs++;
                $display("FAIL unexpected cyc %0d: got %b prev %b", cyc, obs, prev);
            end else begin
                e = q.pop_front();
                if (e.cyc != cyc || obs !== e.v) begin
                    errs++;
                    $display("FAIL event: got %b at cyc %0d want %b at cyc %0d", obs, cyc, e.v, e.cyc);
                end
            end
        end
        prev <= obs;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int o;
        rst = 1'b1; breq1 = 1'b1; breq2 = 1'b1; mvalid = 1'b0; sready = 1'b1;
        #1 chk("reset", {bgrant1, bgrant2, msel, tout}, 4'b0000);
        @(negedge clk);
        chk("reset_hold", {bgrant1, bgrant2, msel, tout}, 4'b0000);
        rst = 1'b0; mvalid = 1'b1;
        push(1, 4'b1000);
        o = 1;
        for (int i = 0; i < 3; i++) begin
            step(2);
            if (o == 1) breq1 = 1'b0; else breq2 = 1'b0;
            push(1, {2'b00, o == 2, 1'b0});
            step(1);
            if (o == 1) breq1 = 1'b1; else breq2 = 1'b1;
            o = 3 - o;
            push(1, {o == 1, o == 2, o == 2, 1'b0});
        end
        step(2);
        breq2 = 1'b0;
        push(1, 4'b0010);
        push(2, 4'b1000);
        step(3);
        breq1 = 1'b0; sready = 1'b0;
        step(5);
        sready = 1'b1;
        push(1, 4'b0000);
        step(1);
        breq1 = 1'b1; breq2 = 1'b1; mvalid = 1'b0;
        push(1, 4'b0110);
        push(13, 4'b0011);
        push(14, 4'b1000);
        step(14);
        breq2 = 1'b0;
        step(11);
        breq1 = 1'b0;
        push(1, 4'b0000);
        step(1);
        mvalid = 1'b1; breq1 = 1'b1; breq2 = 1'b1;
        push(1, 4'b0110);
        step(2);
        push(1, 4'b0000);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst", {bgrant1, bgrant2, msel, tout}, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        push(1, 4'b1000);
        step(2);
        breq1 = 1'b0; breq2 = 1'b0;
        push(1, 4'b0000);
        step(3);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nvec++;
            errs++;
            $display("FAIL missing: no change seen, want %b at cyc %0d", e.v, e.cyc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
